// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch front end with a QDEPTH-entry FIFO toward decode
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hFFFFE000,
    parameter logic [31:0] HALT_PC  = 32'h00008000,
    parameter int          QDEPTH   = 4
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_done,
    input  logic [31:0] ic_ins,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc,
    output logic        halted
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          ic_req_q, ic_req_d;
    logic [31:0]   ic_addr_q, ic_addr_d;
    logic          halted_q, halted_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   ins_mem_q [QDEPTH];
    logic [31:0]   ins_mem_d [QDEPTH];
    logic [31:0]   pc_mem_q  [QDEPTH];
    logic [31:0]   pc_mem_d  [QDEPTH];

    logic          push;
    logic          pop;
    logic [31:0]   pc_inc;
    logic [CW-1:0] count_no_push;
    logic [CW-1:0] count_with_push;

    // Issue FSM, FIFO bookkeeping and redirect override; redirect is applied last so it wins
    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        ic_req_d        = ic_req_q;
        ic_addr_d       = ic_addr_q;
        halted_d        = halted_q;
        push            = 1'b0;
        pop             = (count_q != '0) && out_ready && !redirect;
        pc_inc          = fetch_pc_q + 32'd4;
        count_no_push   = count_q - CW'(pop);
        count_with_push = count_q + CW'(1) - CW'(pop);

        case (state_q)
            S_IDLE: begin
                if (fetch_pc_q == HALT_PC) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (count_no_push < DEPTH_C) begin
                    state_d   = S_REQ;
                    ic_req_d  = 1'b1;
                    ic_addr_d = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (ic_done) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_inc;
                    if (pc_inc == HALT_PC) begin
                        state_d  = S_HALT;
                        ic_req_d = 1'b0;
                        halted_d = 1'b1;
                    end else if (count_with_push < DEPTH_C) begin
                        ic_addr_d = pc_inc;
                    end else begin
                        state_d  = S_IDLE;
                        ic_req_d = 1'b0;
                    end
                end
            end
            S_DROP: begin
                if (ic_done) begin
                    state_d  = S_IDLE;
                    ic_req_d = 1'b0;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d  = S_IDLE;
                ic_req_d = 1'b0;
            end
        endcase

        // A cache request already on the bus must still complete, so it is parked in DROP
        if (redirect) begin
            push       = 1'b0;
            fetch_pc_d = redirect_addr;
            halted_d   = 1'b0;
            ic_addr_d  = ic_addr_q;
            if ((state_q == S_REQ || state_q == S_DROP) && !ic_done) begin
                state_d  = S_DROP;
                ic_req_d = 1'b1;
            end else begin
                state_d  = S_IDLE;
                ic_req_d = 1'b0;
            end
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        ins_mem_d = ins_mem_q;
        pc_mem_d  = pc_mem_q;
        if (push) begin
            ins_mem_d[wr_ptr_q] = ic_ins;
            pc_mem_d[wr_ptr_q]  = ic_addr_q;
        end
    end

    // Control state with synchronous active-low reset; any in-flight response is forgotten
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            ic_req_q   <= 1'b0;
            ic_addr_q  <= RESET_PC;
            halted_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ic_req_q   <= ic_req_d;
            ic_addr_q  <= ic_addr_d;
            halted_q   <= halted_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; entries are only observable through count, so they carry no reset
    always_ff @(posedge sys_clk) begin
        ins_mem_q <= ins_mem_d;
        pc_mem_q  <= pc_mem_d;
    end

    assign ic_req      = ic_req_q;
    assign ic_addr     = ic_addr_q;
    assign halted      = halted_q;
    assign out_valid   = (count_q != '0);
    assign out_ins     = out_valid ? ins_mem_q[rd_ptr_q] : 32'd0;
    assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
    assign out_next_pc = out_valid ? (pc_mem_q[rd_ptr_q] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

    localparam logic [31:0] RESET_PC_C = 32'hFFFFE000;
    localparam logic [31:0] HALT_PC_C  = 32'h00008000;
    localparam int          QDEPTH_C   = 4;

    logic        sys_clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_ins;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];
    logic [31:0] exp_fetch;
    bit          drop_pending;

    ifetch_queue #(
        .RESET_PC(RESET_PC_C),
        .HALT_PC (HALT_PC_C),
        .QDEPTH  (QDEPTH_C)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .ic_req       (ic_req),
        .ic_addr      (ic_addr),
        .ic_done      (ic_done),
        .ic_ins       (ic_ins),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ins      (out_ins),
        .out_pc       (out_pc),
        .out_next_pc  (out_next_pc),
        .halted       (halted)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h13572468;
    endfunction

    // Drive one cycle of inputs, advance the reference model across the edge, sample after it
    task automatic tick(input bit done, input logic [31:0] ins, input bit ready,
                        input bit redir, input logic [31:0] raddr);
        ic_done       = done;
        ic_ins        = ins;
        out_ready     = ready;
        redirect      = redir;
        redirect_addr = raddr;
        if (!rst_n) begin
            mq_pc.delete();
            mq_ins.delete();
            exp_fetch    = RESET_PC_C;
            drop_pending = 0;
        end else if (redir) begin
            drop_pending = ic_req && !done;
            mq_pc.delete();
            mq_ins.delete();
            exp_fetch = raddr;
        end else begin
            if (mq_pc.size() != 0 && ready) begin
                void'(mq_pc.pop_front());
                void'(mq_ins.pop_front());
            end
            if (done && ic_req) begin
                if (drop_pending) begin
                    drop_pending = 0;
                end else begin
                    mq_pc.push_back(exp_fetch);
                    mq_ins.push_back(ins);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
        @(posedge sys_clk);
        #1;
        ic_done  = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(0, 0, 0, 0, 0);
        tick(1, 32'h11111111, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL reset_ic_req got %b exp 0", ic_req); end
        checks++; if (ic_addr !== RESET_PC_C) begin errors++; $display("FAIL reset_ic_addr got %h exp %h", ic_addr, RESET_PC_C); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_ins !== 32'd0) begin errors++; $display("FAIL reset_out_ins got %h exp 0", out_ins); end
        checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
        checks++; if (out_next_pc !== 32'd0) begin errors++; $display("FAIL reset_out_next_pc got %h exp 0", out_next_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 0);
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL release_ic_req got %b exp 1", ic_req); end
        checks++; if (ic_addr !== RESET_PC_C) begin errors++; $display("FAIL release_ic_addr got %h exp %h", ic_addr, RESET_PC_C); end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        for (int i = 0; i < 8; i++) begin
            epc = RESET_PC_C + 32'(4 * i);
            checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL stream_req[%0d] got %b exp 1", i, ic_req); end
            checks++; if (ic_addr !== epc) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, ic_addr, epc); end
            checks++; if (out_valid !== (i != 0)) begin errors++; $display("FAIL stream_valid[%0d] got %b exp %b", i, out_valid, i != 0); end
            if (i != 0) begin
                checks++; if (out_pc !== epc - 32'd4) begin errors++; $display("FAIL stream_out_pc[%0d] got %h exp %h", i, out_pc, epc - 32'd4); end
                checks++; if (out_next_pc !== epc) begin errors++; $display("FAIL stream_next_pc[%0d] got %h exp %h", i, out_next_pc, epc); end
                checks++; if (out_ins !== ins_of(epc - 32'd4)) begin errors++; $display("FAIL stream_ins[%0d] got %h exp %h", i, out_ins, ins_of(epc - 32'd4)); end
            end
            tick(1, ins_of(epc), 1, 0, 0);
        end
    endtask

    task automatic test_backpressure();
        int          pushes;
        bit          seen;
        logic [31:0] next_out;
        do_reset();
        pushes = 0;
        for (int k = 0; k < 12; k++) begin
            if (ic_req) begin
                pushes++;
                tick(1, ins_of(exp_fetch), 0, 0, 0);
            end else begin
                tick(0, 0, 0, 0, 0);
            end
        end
        checks++; if (pushes != QDEPTH_C) begin errors++; $display("FAIL bp_pushes got %0d exp %0d", pushes, QDEPTH_C); end
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL bp_req_low got %b exp 0", ic_req); end
        checks++; if (out_pc !== RESET_PC_C) begin errors++; $display("FAIL bp_head got %h exp %h", out_pc, RESET_PC_C); end
        seen = 0;
        next_out = RESET_PC_C;
        for (int k = 0; k < 30; k++) begin
            if (ic_req && !seen) begin
                seen = 1;
                checks++; if (ic_addr !== 32'hFFFFE010) begin errors++; $display("FAIL bp_restart_addr got %h exp FFFFE010", ic_addr); end
            end
            if (out_valid) begin
                checks++; if (out_pc !== next_out) begin errors++; $display("FAIL bp_seq got %h exp %h", out_pc, next_out); end
                checks++; if (out_ins !== ins_of(next_out)) begin errors++; $display("FAIL bp_ins got %h exp %h", out_ins, ins_of(next_out)); end
                next_out = next_out + 32'd4;
            end
            tick(ic_req, ins_of(exp_fetch), 1, 0, 0);
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_restart_timeout got none exp request"); end
        checks++; if (next_out < 32'hFFFFE030) begin errors++; $display("FAIL bp_progress got %h exp >= FFFFE030", next_out); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        tick(1, ins_of(32'hFFFFE000), 1, 0, 0);
        tick(1, ins_of(32'hFFFFE004), 1, 0, 0);
        checks++; if (ic_addr !== 32'hFFFFE008) begin errors++; $display("FAIL drop_pending_addr got %h exp FFFFE008", ic_addr); end
        tick(0, 0, 1, 1, 32'h100);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_flush got %b exp 0", out_valid); end
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL drop_req_held got %b exp 1", ic_req); end
        checks++; if (ic_addr !== 32'hFFFFE008) begin errors++; $display("FAIL drop_addr_stable got %h exp FFFFE008", ic_addr); end
        tick(0, 0, 1, 0, 0);
        tick(1, 32'hDEADBEEF, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_no_push got %b exp 0", out_valid); end
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL drop_req_low got %b exp 0", ic_req); end
        tick(0, 0, 1, 0, 0);
        checks++; if (ic_req !== 1'b1 || ic_addr !== 32'h100) begin errors++; $display("FAIL drop_refetch got %b/%h exp 1/00000100", ic_req, ic_addr); end
        tick(1, ins_of(32'h100), 1, 0, 0);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL drop_first got %b/%h exp 1/00000100", out_valid, out_pc); end
        checks++; if (out_next_pc !== 32'h104) begin errors++; $display("FAIL drop_next_pc got %h exp 00000104", out_next_pc); end
        checks++; if (out_ins !== ins_of(32'h100)) begin errors++; $display("FAIL drop_ins got %h exp %h", out_ins, ins_of(32'h100)); end
    endtask

    task automatic test_redirect_with_done();
        tick(1, ins_of(32'h104), 1, 1, 32'h200);
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0) begin errors++; $display("FAIL rdone_empty got %b/%h exp 0/0", out_valid, out_pc); end
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL rdone_req_low got %b exp 0", ic_req); end
        tick(0, 0, 1, 0, 0);
        checks++; if (ic_req !== 1'b1 || ic_addr !== 32'h200) begin errors++; $display("FAIL rdone_refetch got %b/%h exp 1/00000200", ic_req, ic_addr); end
    endtask

    task automatic test_halt_and_wrap();
        tick(1, ins_of(32'h200), 1, 1, 32'h7FF8);
        tick(0, 0, 1, 0, 0);
        checks++; if (ic_addr !== 32'h7FF8) begin errors++; $display("FAIL halt_a0 got %h exp 00007FF8", ic_addr); end
        tick(1, ins_of(32'h7FF8), 1, 0, 0);
        checks++; if (ic_addr !== 32'h7FFC || ic_req !== 1'b1) begin errors++; $display("FAIL halt_a1 got %b/%h exp 1/00007FFC", ic_req, ic_addr); end
        tick(1, ins_of(32'h7FFC), 1, 0, 0);
        checks++; if (halted !== 1'b1 || ic_req !== 1'b0) begin errors++; $display("FAIL halt_enter got %b/%b exp 1/0", halted, ic_req); end
        checks++; if (out_pc !== 32'h7FFC) begin errors++; $display("FAIL halt_last got %h exp 00007FFC", out_pc); end
        for (int k = 0; k < 3; k++) tick(0, 0, 1, 0, 0);
        checks++; if (halted !== 1'b1 || ic_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_hold got %b/%b/%b exp 1/0/0", halted, ic_req, out_valid); end
        tick(0, 0, 1, 1, 32'h0);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b exp 0", halted); end
        tick(0, 0, 1, 0, 0);
        checks++; if (ic_req !== 1'b1 || ic_addr !== 32'h0) begin errors++; $display("FAIL halt_resume got %b/%h exp 1/00000000", ic_req, ic_addr); end
        tick(1, ins_of(32'h0), 1, 0, 0);
        tick(1, ins_of(32'h4), 1, 1, 32'hFFFFFFFC);
        tick(0, 0, 1, 0, 0);
        checks++; if (ic_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_a0 got %h exp FFFFFFFC", ic_addr); end
        tick(1, ins_of(32'hFFFFFFFC), 1, 0, 0);
        checks++; if (ic_addr !== 32'h0 || ic_req !== 1'b1) begin errors++; $display("FAIL wrap_a1 got %b/%h exp 1/00000000", ic_req, ic_addr); end
        checks++; if (out_pc !== 32'hFFFFFFFC || out_next_pc !== 32'h0) begin errors++; $display("FAIL wrap_out got %h/%h exp FFFFFFFC/00000000", out_pc, out_next_pc); end
    endtask

    task automatic test_reset_midreq();
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL midreq_pre got %b exp 1", ic_req); end
        rst_n = 1'b0;
        tick(0, 0, 1, 0, 0);
        checks++; if (ic_req !== 1'b0 || ic_addr !== RESET_PC_C) begin errors++; $display("FAIL midreq_req got %b/%h exp 0/%h", ic_req, ic_addr, RESET_PC_C); end
        checks++; if (out_valid !== 1'b0 || out_ins !== 32'd0 || out_pc !== 32'd0 || out_next_pc !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL midreq_outs got %b/%h/%h/%h/%b exp 0/0/0/0/0", out_valid, out_ins, out_pc, out_next_pc, halted); end
        rst_n = 1'b1;
        tick(1, 32'hDEADBEEF, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreq_stale got %b exp 0", out_valid); end
        checks++; if (ic_req !== 1'b1 || ic_addr !== RESET_PC_C) begin errors++; $display("FAIL midreq_restart got %b/%h exp 1/%h", ic_req, ic_addr, RESET_PC_C); end
        tick(1, ins_of(RESET_PC_C), 1, 0, 0);
        checks++; if (out_pc !== RESET_PC_C || out_ins !== ins_of(RESET_PC_C)) begin errors++; $display("FAIL midreq_first got %h/%h exp %h/%h", out_pc, out_ins, RESET_PC_C, ins_of(RESET_PC_C)); end
    endtask

    task automatic test_random();
        logic [31:0] e_pc, e_ins, e_next, raddr;
        bit          rd, dn, rdy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            e_pc   = (mq_pc.size() != 0) ? mq_pc[0] : 32'd0;
            e_ins  = (mq_ins.size() != 0) ? mq_ins[0] : 32'd0;
            e_next = (mq_pc.size() != 0) ? mq_pc[0] + 32'd4 : 32'd0;
            checks++; if (out_valid !== (mq_pc.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, out_valid, mq_pc.size() != 0); end
            checks++; if (out_pc !== e_pc) begin errors++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, out_pc, e_pc); end
            checks++; if (out_ins !== e_ins) begin errors++; $display("FAIL rnd_ins c=%0d got %h exp %h", c, out_ins, e_ins); end
            checks++; if (out_next_pc !== e_next) begin errors++; $display("FAIL rnd_next c=%0d got %h exp %h", c, out_next_pc, e_next); end
            checks++; if (mq_pc.size() > QDEPTH_C) begin errors++; $display("FAIL rnd_overflow c=%0d got %0d exp <= %0d", c, mq_pc.size(), QDEPTH_C); end
            if (ic_req && !drop_pending) begin
                checks++; if (ic_addr !== exp_fetch) begin errors++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, ic_addr, exp_fetch); end
            end
            if (halted) begin
                checks++; if (exp_fetch !== HALT_PC_C) begin errors++; $display("FAIL rnd_halt c=%0d got halted at %h exp %h", c, exp_fetch, HALT_PC_C); end
            end
            rdy = ($urandom_range(0, 3) != 0);
            dn  = ic_req && ($urandom_range(0, 2) != 0);
            rd  = halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       raddr = HALT_PC_C - 32'd8;
                1:       raddr = 32'hFFFFFFF8;
                2:       raddr = $urandom & 32'h0000FFFC;
                default: raddr = $urandom & 32'hFFFFFFFC;
            endcase
            tick(dn, $urandom, rdy, rd, raddr);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 32'd0;
        ic_done       = 1'b0;
        ic_ins        = 32'd0;
        out_ready     = 1'b0;
        exp_fetch     = RESET_PC_C;
        drop_pending  = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_with_done();
        test_halt_and_wrap();
        test_reset_midreq();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
